// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: bitwise logic unit feeding an elastic valid/ready register pipeline.
// Unsupported opcodes yield zero data with err set; results leave in acceptance order.
package logic_unit_pkg;
    typedef logic [3:0] func_t;
    localparam func_t OP_AND  = 4'b0101;
    localparam func_t OP_OR   = 4'b1101;
    localparam func_t OP_XOR  = 4'b1111;
    localparam func_t OP_NOT  = 4'b0111;
    localparam func_t OP_NAND = 4'b0001;
    localparam func_t OP_NOR  = 4'b1001;
    localparam func_t OP_XNOR = 4'b1011;
    localparam func_t OP_ANDN = 4'b0011;
endpackage

module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  func_t                 opcode_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] logic_out_o,
    output logic                  err_o,
    output logic                  valid_o,
    input  logic                  ready_i
);
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_err;
    logic [STAGES-1:0]     r_valid;
    logic [STAGES-1:0]     r_err;
    logic [DATA_WIDTH-1:0] r_data     [STAGES];
    logic [DATA_WIDTH-1:0] w_nxt_data [STAGES];
    logic [STAGES-1:0]     w_nxt_err;
    logic [STAGES-1:0]     w_adv;
    logic [STAGES-1:0]     w_load;

    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (opcode_i)
            OP_AND:  w_res = rs1_data_i & rs2_data_i;
            OP_OR:   w_res = rs1_data_i | rs2_data_i;
            OP_XOR:  w_res = rs1_data_i ^ rs2_data_i;
            OP_NOT:  w_res = ~rs1_data_i;
            OP_NAND: w_res = ~(rs1_data_i & rs2_data_i);
            OP_NOR:  w_res = ~(rs1_data_i | rs2_data_i);
            OP_XNOR: w_res = ~(rs1_data_i ^ rs2_data_i);
            OP_ANDN: w_res = rs1_data_i & ~rs2_data_i;
            default: w_err = 1'b1;
        endcase
    end

    // A stage moves on when any later stage is empty or the sink is taking the output;
    // written as a flat reduction so there is no combinational chain between stages.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == STAGES - 1) begin : g_last
            assign w_adv[i] = r_valid[i] & ready_i;
        end else begin : g_mid
            assign w_adv[i] = r_valid[i] & (ready_i | ~&r_valid[STAGES-1:i+1]);
        end
        if (i == 0) begin : g_head
            assign w_load[i]     = valid_i & ready_o;
            assign w_nxt_data[i] = w_res;
            assign w_nxt_err[i]  = w_err;
        end else begin : g_tail
            assign w_load[i]     = w_adv[i-1];
            assign w_nxt_data[i] = r_data[i-1];
            assign w_nxt_err[i]  = r_err[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_valid <= '0;
            r_err   <= '0;
            for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= w_nxt_data[k];
                    r_err[k]   <= w_nxt_err[k];
                end else if (w_adv[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign ready_o     = ~r_valid[0] | w_adv[0];
    assign logic_out_o = r_data[STAGES-1];
    assign err_o       = r_err[STAGES-1];
    assign valid_o     = r_valid[STAGES-1];

`ifndef SYNTHESIS
    initial begin
        if (DATA_WIDTH > 32) $warning("logic_unit_pipe: DATA_WIDTH %0d exceeds 32", DATA_WIDTH);
        if (STAGES < 1 || STAGES > 4) $error("logic_unit_pipe: STAGES %0d outside 1..4", STAGES);
    end

    a_hold: assert property (@(posedge clk_i) disable iff (arst_i)
        valid_o && !ready_i |=> valid_o && $stable(logic_out_o) && $stable(err_o));
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed and randomized checks of logic_unit_pipe against a
// queue-based reference model; also checks the single- and four-stage builds.
module tb_logic_unit_pipe;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         arst = 1'b0;
    logic [W-1:0] rs1 = '0, rs2 = '0;
    logic [3:0]   op = '0;
    logic         valid_i = 1'b0, ready_i = 1'b1;
    logic         ready_o, err_o, valid_o;
    logic [W-1:0] out;

    logic [W-1:0] xa = 8'hAA, xb = 8'h0F;
    logic [3:0]   xop = 4'b0101;
    logic         xv = 1'b0;
    logic         x1_ready, x1_err, x1_valid, x4_ready, x4_err, x4_valid;
    logic [W-1:0] x1_out, x4_out;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.DATA_WIDTH(W), .STAGES(2)) u_dut (
        .clk_i(clk), .arst_i(arst), .rs1_data_i(rs1), .rs2_data_i(rs2), .opcode_i(op),
        .valid_i(valid_i), .ready_o(ready_o), .logic_out_o(out), .err_o(err_o),
        .valid_o(valid_o), .ready_i(ready_i));

    logic_unit_pipe #(.DATA_WIDTH(W), .STAGES(1)) u_dut1 (
        .clk_i(clk), .arst_i(arst), .rs1_data_i(xa), .rs2_data_i(xb), .opcode_i(xop),
        .valid_i(xv), .ready_o(x1_ready), .logic_out_o(x1_out), .err_o(x1_err),
        .valid_o(x1_valid), .ready_i(1'b1));

    logic_unit_pipe #(.DATA_WIDTH(W), .STAGES(4)) u_dut4 (
        .clk_i(clk), .arst_i(arst), .rs1_data_i(xa), .rs2_data_i(xb), .opcode_i(xop),
        .valid_i(xv), .ready_o(x4_ready), .logic_out_o(x4_out), .err_o(x4_err),
        .valid_o(x4_valid), .ready_i(1'b1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W:0] ref_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            4'b0101: return {1'b0, a & b};
            4'b1101: return {1'b0, a | b};
            4'b1111: return {1'b0, a ^ b};
            4'b0111: return {1'b0, ~a};
            4'b0001: return {1'b0, ~(a & b)};
            4'b1001: return {1'b0, ~(a | b)};
            4'b1011: return {1'b0, ~(a ^ b)};
            4'b0011: return {1'b0, a & ~b};
            default: return {1'b1, {W{1'b0}}};
        endcase
    endfunction

    typedef struct { logic [W-1:0] d; logic e; int c; } exp_t;
    exp_t       q[$];
    int         cyc = 0, last_stall = -1, n_out = 0;
    bit         head_new = 1'b1;
    logic [W:0] ref_r;

    // Scoreboard: every accepted op must come out once, in order, with 2-cycle latency
    // whenever the sink has been ready since acceptance.
    always @(negedge clk) begin
        cyc++;
        if (arst) begin
            q.delete();
            head_new = 1'b1;
            chk("rst_valid", valid_o, 0);
            chk("rst_data", out, 0);
            chk("rst_err", err_o, 0);
            chk("rst_ready", ready_o, 1);
        end else begin
            if (q.size() == 0) chk("idle_valid", valid_o, 0);
            else if (valid_o) begin
                chk("data", out, q[0].d);
                chk("err", err_o, q[0].e);
                if (head_new && last_stall < q[0].c) chk("latency", cyc - q[0].c, 2);
                head_new = 1'b0;
            end
            if (!ready_i) last_stall = cyc;
            if (valid_o && ready_i && q.size() > 0) begin
                void'(q.pop_front());
                head_new = 1'b1;
                n_out++;
            end
            if (valid_i && ready_o) begin
                ref_r = ref_op(op, rs1, rs2);
                q.push_back('{ref_r[W-1:0], ref_r[W], cyc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        valid_i = v;
        op      = o;
        rs1     = a;
        rs2     = b;
    endtask

    logic [3:0]   ops[8]     = '{4'b0101, 4'b1101, 4'b1111, 4'b0111, 4'b0001, 4'b1001, 4'b1011, 4'b0011};
    logic [W-1:0] ops_exp[8] = '{8'h30, 8'hFC, 8'hCC, 8'h0F, 8'hCF, 8'h03, 8'h33, 8'hC0};

    initial begin
        int n0, lat1, lat4;
        #1 arst = 1'b1;
        #1;
        chk("rst_imm_valid", valid_o, 0);
        chk("rst_imm_ready", ready_o, 1);
        chk("rst_imm_data", out, 0);
        repeat (2) @(posedge clk);
        #2 arst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            step();
            if (k < 8) drive(1'b1, ops[k], 8'hF0, 8'h3C);
            else valid_i = 1'b0;
            peek();
            if (k >= 2) begin
                chk("ops_data", out, ops_exp[k-2]);
                chk("ops_valid", valid_o, 1);
                chk("ops_err", err_o, 0);
            end
        end

        step(); drive(1'b1, 4'b0000, 8'hFF, 8'h00);
        step(); valid_i = 1'b0;
        peek(); chk("ill_early", valid_o, 0);
        step(); peek();
        chk("ill_valid", valid_o, 1);
        chk("ill_data", out, 0);
        chk("ill_err", err_o, 1);

        step(); ready_i = 1'b0; drive(1'b1, 4'b0101, 8'hAA, 8'h0F);
        step(); drive(1'b1, 4'b0101, 8'h55, 8'hFF);
        step(); drive(1'b1, 4'b0101, 8'h3C, 8'hF0);
        peek(); chk("bp_ready", ready_o, 0);
        for (int k = 0; k < 2; k++) begin
            step(); peek();
            chk("bp_ready", ready_o, 0);
            chk("bp_valid", valid_o, 1);
            chk("bp_hold", out, 8'h0A);
        end
        step(); ready_i = 1'b1; n0 = n_out;
        peek(); chk("bp_resume_ready", ready_o, 1);
        step(); valid_i = 1'b0;
        repeat (4) begin step(); peek(); end
        chk("bp_count", n_out - n0, 3);

        for (int k = 0; k < 12; k++) begin
            step(); drive(1'b1, 4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
            peek(); chk("tp_ready", ready_o, 1);
            if (k == 1) n0 = n_out;
        end
        chk("tp_count", n_out - n0, 10);
        step(); valid_i = 1'b0;

        step(); drive(1'b1, 4'b1101, 8'h12, 8'h34);
        step(); drive(1'b1, 4'b1111, 8'h0F, 8'hFF);
        step(); valid_i = 1'b0;
        chk("mid_pre_valid", valid_o, 1);
        #1 arst = 1'b1;
        #1;
        chk("mid_valid", valid_o, 0);
        chk("mid_data", out, 0);
        chk("mid_err", err_o, 0);
        chk("mid_ready", ready_o, 1);
        step();
        #1 arst = 1'b0;
        chk("post_rst_ready", ready_o, 1);
        drive(1'b1, 4'b0101, 8'hAA, 8'h0F);
        step(); valid_i = 1'b0;
        peek(); chk("post_rst_early", valid_o, 0);
        step(); peek();
        chk("post_rst_valid", valid_o, 1);
        chk("post_rst_data", out, 8'h0A);

        chk("s1_ready", x1_ready, 1);
        chk("s4_ready", x4_ready, 1);
        lat1 = -1;
        lat4 = -1;
        step(); xv = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) xv = 1'b0;
            peek();
            if (x1_valid && lat1 < 0) begin
                lat1 = k;
                chk("s1_data", x1_out, 8'h0A);
                chk("s1_err", x1_err, 0);
            end
            if (x4_valid && lat4 < 0) begin
                lat4 = k;
                chk("s4_data", x4_out, 8'h0A);
                chk("s4_err", x4_err, 0);
            end
        end
        chk("s1_latency", lat1, 1);
        chk("s4_latency", lat4, 4);

        for (int k = 0; k < 400; k++) begin
            step();
            if (k == 201) #1 arst = 1'b0;
            ready_i = ($urandom_range(0, 9) < 7);
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
            if (k == 200) #1 arst = 1'b1;
        end

        ready_i = 1'b1;
        valid_i = 1'b0;
        repeat (10) begin step(); peek(); end
        chk("drain_empty", q.size(), 0);
        chk("drain_valid", valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and result width in bits (legal range 1..64).
REQ-002 SHALL have parameter STAGES, default 2, number of pipeline register stages (legal range 1..4).
REQ-003 SHALL have port clk_i, input, 1 bit, single clock; all state is updated on its rising edge.
REQ-004 SHALL have port arst_i, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port rs1_data_i, input, DATA_WIDTH bits, operand 1.
REQ-006 SHALL have port rs2_data_i, input, DATA_WIDTH bits, operand 2.
REQ-007 SHALL have port opcode_i, input, func_t (4 bits), operation select.
REQ-008 SHALL have port valid_i, input, 1 bit, upstream operation valid.
REQ-009 SHALL have port ready_o, output, 1 bit, block can accept an operation.
REQ-010 SHALL have port logic_out_o, output, DATA_WIDTH bits, result.
REQ-011 SHALL have port err_o, output, 1 bit, result came from an unsupported opcode.
REQ-012 SHALL have port valid_o, output, 1 bit, result valid.
REQ-013 SHALL have port ready_i, input, 1 bit, downstream accepts result.

Function
REQ-014 SHALL decode opcode_i as follows: 0101 AND; 1101 OR; 1111 XOR; 0111 NOT rs1; 0001 NAND; 1001 NOR; 1011 XNOR; 0011 ANDN (rs1 & ~rs2).
REQ-015 SHALL, for any other opcode, produce a result of all-zeros with err set; the output SHALL never be driven to high impedance.
REQ-016 SHALL accept an operation on a clock edge where valid_i and ready_o are both high; this is the input transfer.
REQ-017 SHALL compute the result combinationally from the accepted operands and capture it, together with err, into stage 0.
REQ-018 SHALL implement STAGES register stages; each stage holds data, err and a valid bit.
REQ-019 SHALL drive logic_out_o, err_o and valid_o directly from the last stage.
REQ-020 SHALL make the latency from input transfer to valid_o exactly STAGES cycles when ready_i has been held high.
REQ-021 SHALL advance a stage when its successor is empty or advancing; the last stage advances when ready_i is high; an empty stage may always be loaded (bubble collapse).
REQ-022 SHALL derive ready_o as stage 0 empty OR stage 0 advancing; there SHALL be no combinational path from valid_i to ready_o.
REQ-023 SHALL hold logic_out_o, err_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-024 SHALL, when all stages are full and ready_i is held low, keep ready_o=0 and neither drop nor duplicate any operation.
REQ-025 SHALL, when an output transfer and an input transfer occur in the same cycle at full occupancy, sustain 1 operation per cycle with no bubble.
REQ-026 SHALL sustain full throughput of 1 operation per cycle while ready_i=1, and deliver results strictly in acceptance order.
REQ-027 SHALL leave data registers unchanged when their stage is not loaded.
REQ-028 SHALL, in simulation only, emit a warning at time 0 if DATA_WIDTH > 32 and an error if STAGES is outside 1..4.

Reset
REQ-029 SHALL, while arst_i=1, immediately clear every stage valid bit, independent of clk_i.
REQ-030 SHALL, while arst_i=1, hold valid_o=0, err_o=0, logic_out_o=0 and ready_o=1.
REQ-031 SHALL, on a reset asserted mid-operation, discard all in-flight operations; no result is ever produced for them after reset.
REQ-032 SHALL accept a new operation on the first rising edge after arst_i deasserts.

Verification
REQ-033 SHALL verify ops with DATA_WIDTH=8, STAGES=2, ready_i=1: rs1=0xF0, rs2=0x3C, apply each opcode back-to-back -> results AND 0x30, OR 0xFC, XOR 0xCC, NOT 0x0F, NAND 0xCF, NOR 0x03, XNOR 0x33, ANDN 0xC0, each appearing 2 cycles after acceptance, on consecutive cycles, with err_o=0.
REQ-034 SHALL verify the illegal opcode: opcode 0000, rs1=0xFF -> logic_out_o=0x00, err_o=1, valid_o=1 after 2 cycles.
REQ-035 SHALL verify backpressure: ready_i=0 with 3 operations offered -> ready_o falls after 2 are accepted, output holds the first result stable; when ready_i is raised, all 3 results emerge in order with no loss.
REQ-036 SHALL verify simultaneous transfer: full pipe, valid_i=1 and ready_i=1 held for 10 cycles -> 10 results in 10 cycles, ready_o constantly 1.
REQ-037 SHALL verify reset mid-flight: arst_i pulsed while 2 operations are in flight -> valid_o=0 and logic_out_o=0 immediately, ready_o=1, no stale result after release.
REQ-038 SHALL verify STAGES=1 and STAGES=4 builds: single AND 0xAA & 0x0F -> 0x0A, with latency 1 and 4 cycles respectively.
